// File: rtl/sb_pkg.sv
// Shared constants for the N-pending issue scoreboard.
// Stall-cause bit positions, functional unit indices and counter helpers.
package sb_pkg;

    localparam int SB_RAW    = 0;
    localparam int SB_WAW    = 1;
    localparam int SB_STRUCT = 2;

    localparam int FU_ALU0 = 0;
    localparam int FU_ALU1 = 1;
    localparam int FU_DIV  = 2;
    localparam int FU_MEM  = 3;
    localparam int FU_BR   = 4;

    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sb_updown_cnt.sv
// Saturating up/down counter; LOAD_MODE=1 turns it into a load-then-drain
// occupancy timer (dec tied high, inc unused).
module sb_updown_cnt
    import sb_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter bit LOAD_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             zero,
    output logic             max,
    output logic             underflow
);

    assign zero = (cnt == '0);
    assign max  = (cnt == WIDTH'(cnt_max(WIDTH)));

    // A release with nothing outstanding is a bookkeeping error upstream.
    assign underflow = !LOAD_MODE && dec && !inc && zero && !clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (LOAD_MODE && load) begin
            cnt <= load_val;
        end else if (inc && !dec && !max) begin
            cnt <= cnt + WIDTH'(1);
        end else if (dec && !inc && !zero) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

endmodule

// File: rtl/scoreboard_issue_n.sv
// In-order issue scoreboard with per-register pending counters and unit timers.
// Optional macro SB_WB_BYPASS_EN lets a source issue in its writeback cycle.
module scoreboard_issue_n
    import sb_pkg::*;
#(
    parameter int REG_ADDR_SIZE  = 5,
    parameter int PRED_ADDR_SIZE = 3,
    parameter int NUM_FUNC_UNITS = 5,
    parameter int FU_ID_SIZE     = 3,
    parameter int LAT_WIDTH      = 4,
    parameter int PEND_CNT_WIDTH = 2,
    parameter logic [NUM_FUNC_UNITS-1:0] UNIT_PIPELINED = 5'b11011
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dec_valid,
    input  logic                      pred_ins,
    input  logic [PRED_ADDR_SIZE-1:0] pred_addr,
    input  logic                      reg_dest_valid,
    input  logic [REG_ADDR_SIZE-1:0]  reg_dest_addr,
    input  logic                      reg_src1_valid,
    input  logic [REG_ADDR_SIZE-1:0]  reg_src1_addr,
    input  logic                      reg_src2_valid,
    input  logic [REG_ADDR_SIZE-1:0]  reg_src2_addr,
    input  logic                      pred_dest_valid,
    input  logic [PRED_ADDR_SIZE-1:0] pred_dest_addr,
    input  logic                      pred_src1_valid,
    input  logic [PRED_ADDR_SIZE-1:0] pred_src1_addr,
    input  logic                      pred_src2_valid,
    input  logic [PRED_ADDR_SIZE-1:0] pred_src2_addr,
    input  logic [FU_ID_SIZE-1:0]     func_unit,
    input  logic [LAT_WIDTH-1:0]      latency,
    input  logic                      ex_ready,
    input  logic                      wr_reg_en,
    input  logic [REG_ADDR_SIZE-1:0]  wr_reg_addr,
    input  logic                      wr_pred_en,
    input  logic [PRED_ADDR_SIZE-1:0] wr_pred_addr,
    input  logic                      flush,
    output logic                      issue,
    output logic                      stall,
    output logic [2:0]                stall_cause,
    output logic                      predicate_valid,
    output logic [NUM_FUNC_UNITS-1:0] fu_busy,
    output logic                      sb_error
);

    localparam int NG = 2 ** REG_ADDR_SIZE;
    localparam int NP = 2 ** PRED_ADDR_SIZE;
    localparam int NF = 2 ** FU_ID_SIZE;
    localparam int PW = PEND_CNT_WIDTH;

    logic [NG-1:0][PW-1:0] gcnt;
    logic [NG-1:0]         g_inc, g_dec, gzero, gmax, gfree, g_uf;

    logic [NP-1:0][PW-1:0] pcnt;
    logic [NP-1:0]         p_inc, p_dec, pzero, pmax, pfree, p_uf;

    logic [NUM_FUNC_UNITS-1:0][LAT_WIDTH-1:0] fcnt;
    logic [NUM_FUNC_UNITS-1:0] f_load, fzero, fmax, f_uf, busy_int;
    logic [NF-1:0]             busy_ext;

    logic raw, waw, structural, pred_ok;
    logic stall_int, issue_int;

    for (genvar i = 0; i < NG; i++) begin : g_gpr
        assign g_inc[i] = issue_int && reg_dest_valid &&
                          (reg_dest_addr == REG_ADDR_SIZE'(i));
        assign g_dec[i] = wr_reg_en && !flush &&
                          (wr_reg_addr == REG_ADDR_SIZE'(i));

        sb_updown_cnt #(
            .WIDTH     (PW),
            .LOAD_MODE (1'b0)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .clr       (flush),
            .inc       (g_inc[i]),
            .dec       (g_dec[i]),
            .load      (1'b0),
            .load_val  ('0),
            .cnt       (gcnt[i]),
            .zero      (gzero[i]),
            .max       (gmax[i]),
            .underflow (g_uf[i])
        );

`ifdef SB_WB_BYPASS_EN
        assign gfree[i] = gzero[i] ||
                          (g_dec[i] && (gcnt[i] == PW'(1)));
`else
        assign gfree[i] = gzero[i];
`endif
    end

    for (genvar i = 0; i < NP; i++) begin : g_pred
        assign p_inc[i] = issue_int && pred_dest_valid &&
                          (pred_dest_addr == PRED_ADDR_SIZE'(i));
        assign p_dec[i] = wr_pred_en && !flush &&
                          (wr_pred_addr == PRED_ADDR_SIZE'(i));

        sb_updown_cnt #(
            .WIDTH     (PW),
            .LOAD_MODE (1'b0)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .clr       (flush),
            .inc       (p_inc[i]),
            .dec       (p_dec[i]),
            .load      (1'b0),
            .load_val  ('0),
            .cnt       (pcnt[i]),
            .zero      (pzero[i]),
            .max       (pmax[i]),
            .underflow (p_uf[i])
        );

`ifdef SB_WB_BYPASS_EN
        assign pfree[i] = pzero[i] ||
                          (p_dec[i] && (pcnt[i] == PW'(1)));
`else
        assign pfree[i] = pzero[i];
`endif
    end

    // Only non-pipelined units with multi-cycle latency hold off the next op.
    for (genvar i = 0; i < NUM_FUNC_UNITS; i++) begin : g_fu
        assign f_load[i] = issue_int && !UNIT_PIPELINED[i] &&
                           (func_unit == FU_ID_SIZE'(i)) &&
                           (latency > LAT_WIDTH'(1));

        sb_updown_cnt #(
            .WIDTH     (LAT_WIDTH),
            .LOAD_MODE (1'b1)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .clr       (flush),
            .inc       (1'b0),
            .dec       (1'b1),
            .load      (f_load[i]),
            .load_val  (latency - LAT_WIDTH'(1)),
            .cnt       (fcnt[i]),
            .zero      (fzero[i]),
            .max       (fmax[i]),
            .underflow (f_uf[i])
        );

        assign busy_int[i] = !fzero[i];
    end

    // Out-of-range unit indices land on zero-padded bits: never busy.
    assign busy_ext   = NF'(busy_int);
    assign structural = busy_ext[func_unit];

    assign pred_ok = !pred_ins || pfree[pred_addr];

    assign raw = (reg_src1_valid  && !gfree[reg_src1_addr])  ||
                 (reg_src2_valid  && !gfree[reg_src2_addr])  ||
                 (pred_src1_valid && !pfree[pred_src1_addr]) ||
                 (pred_src2_valid && !pfree[pred_src2_addr]) ||
                 !pred_ok;

    assign waw = (reg_dest_valid  && gmax[reg_dest_addr]) ||
                 (pred_dest_valid && pmax[pred_dest_addr]);

    assign stall_int = dec_valid &&
                       (raw || waw || structural || !ex_ready || flush);
    assign issue_int = dec_valid && !stall_int;

    assign issue           = !reset && issue_int;
    assign stall           = !reset && stall_int;
    assign predicate_valid = reset || pred_ok;
    assign fu_busy         = reset ? '0 : busy_int;

    always_comb begin
        stall_cause = '0;
        if (!reset && dec_valid) begin
            stall_cause[SB_RAW]    = raw;
            stall_cause[SB_WAW]    = waw;
            stall_cause[SB_STRUCT] = structural;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_error <= 1'b0;
        end else if (|{g_uf, p_uf}) begin
            sb_error <= 1'b1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{gcnt, pcnt, fcnt, fmax, f_uf};

endmodule

// File: tb/tb_scoreboard_issue_n.sv
// Directed bench for scoreboard_issue_n; follows SB_WB_BYPASS_EN if defined.
module tb_scoreboard_issue_n;
    import sb_pkg::*;

`ifdef SB_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_valid, pred_ins;
    logic [2:0] pred_addr;
    logic       reg_dest_valid, reg_src1_valid, reg_src2_valid;
    logic [4:0] reg_dest_addr, reg_src1_addr, reg_src2_addr;
    logic       pred_dest_valid, pred_src1_valid, pred_src2_valid;
    logic [2:0] pred_dest_addr, pred_src1_addr, pred_src2_addr;
    logic [2:0] func_unit;
    logic [3:0] latency;
    logic       ex_ready, wr_reg_en, wr_pred_en, flush;
    logic [4:0] wr_reg_addr;
    logic [2:0] wr_pred_addr;
    logic       issue, stall, predicate_valid, sb_error;
    logic [2:0] stall_cause;
    logic [4:0] fu_busy;

    int checks = 0;
    int fails  = 0;

    scoreboard_issue_n dut (
        .clk             (clk),
        .reset           (reset),
        .dec_valid       (dec_valid),
        .pred_ins        (pred_ins),
        .pred_addr       (pred_addr),
        .reg_dest_valid  (reg_dest_valid),
        .reg_dest_addr   (reg_dest_addr),
        .reg_src1_valid  (reg_src1_valid),
        .reg_src1_addr   (reg_src1_addr),
        .reg_src2_valid  (reg_src2_valid),
        .reg_src2_addr   (reg_src2_addr),
        .pred_dest_valid (pred_dest_valid),
        .pred_dest_addr  (pred_dest_addr),
        .pred_src1_valid (pred_src1_valid),
        .pred_src1_addr  (pred_src1_addr),
        .pred_src2_valid (pred_src2_valid),
        .pred_src2_addr  (pred_src2_addr),
        .func_unit       (func_unit),
        .latency         (latency),
        .ex_ready        (ex_ready),
        .wr_reg_en       (wr_reg_en),
        .wr_reg_addr     (wr_reg_addr),
        .wr_pred_en      (wr_pred_en),
        .wr_pred_addr    (wr_pred_addr),
        .flush           (flush),
        .issue           (issue),
        .stall           (stall),
        .stall_cause     (stall_cause),
        .predicate_valid (predicate_valid),
        .fu_busy         (fu_busy),
        .sb_error        (sb_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next low phase and present an idle bus.
    task automatic next();
        @(negedge clk);
        dec_valid = 0; pred_ins = 0; pred_addr = 0;
        reg_dest_valid = 0; reg_dest_addr = 0;
        reg_src1_valid = 0; reg_src1_addr = 0;
        reg_src2_valid = 0; reg_src2_addr = 0;
        pred_dest_valid = 0; pred_dest_addr = 0;
        pred_src1_valid = 0; pred_src1_addr = 0;
        pred_src2_valid = 0; pred_src2_addr = 0;
        func_unit = FU_ALU0; latency = 1; ex_ready = 1;
        wr_reg_en = 0; wr_reg_addr = 0;
        wr_pred_en = 0; wr_pred_addr = 0;
        flush = 0;
    endtask

    initial begin
        reset = 1;
        next();
        dec_valid = 1; ex_ready = 0; pred_ins = 1; #1;
        chk("rst_issue", issue, 0);
        chk("rst_stall", stall, 0);
        chk("rst_cause", stall_cause, 0);
        chk("rst_pvalid", predicate_valid, 1);
        chk("rst_busy", fu_busy, 0);
        chk("rst_err", sb_error, 0);
        next();
        reset = 0;

        next();
        dec_valid = 1; reg_src1_valid = 1; reg_src1_addr = 3; #1;
        chk("r3_issue", issue, 1);
        chk("r3_cause", stall_cause, 0);
        chk("r3_busy", fu_busy, 0);

        next();
        dec_valid = 1; reg_dest_valid = 1; reg_dest_addr = 5; #1;
        chk("r5_dest_issue", issue, 1);
        next();
        dec_valid = 1; reg_src1_valid = 1; reg_src1_addr = 5; #1;
        chk("r5_raw_stall", stall, 1);
        chk("r5_raw_cause", stall_cause, 3'b001);
        next();
        dec_valid = 1; reg_src1_valid = 1; reg_src1_addr = 5;
        wr_reg_en = 1; wr_reg_addr = 5; #1;
        chk("r5_wb_issue", issue, BYP);
        next();
        dec_valid = 1; reg_src1_valid = 1; reg_src1_addr = 5; #1;
        chk("r5_after_wb", issue, 1);

        for (int i = 0; i < 3; i++) begin
            next();
            dec_valid = 1; reg_dest_valid = 1; reg_dest_addr = 7; #1;
            chk($sformatf("r7_fill%0d", i), issue, 1);
        end
        next();
        dec_valid = 1; reg_dest_valid = 1; reg_dest_addr = 7; #1;
        chk("r7_sat_stall", stall, 1);
        chk("r7_sat_cause", stall_cause, 3'b010);
        next();
        dec_valid = 1; reg_dest_valid = 1; reg_dest_addr = 7;
        wr_reg_en = 1; wr_reg_addr = 7; #1;
        chk("r7_wb_cycle", stall_cause, 3'b010);
        next();
        dec_valid = 1; reg_dest_valid = 1; reg_dest_addr = 7; #1;
        chk("r7_reissue", issue, 1);
        for (int i = 0; i < 3; i++) begin
            next();
            wr_reg_en = 1; wr_reg_addr = 7;
        end
        next(); #1;
        chk("r7_no_err", sb_error, 0);

        next();
        dec_valid = 1; func_unit = FU_DIV; latency = 4; #1;
        chk("div_issue", issue, 1);
        next();
        dec_valid = 1; func_unit = FU_DIV; latency = 4; #1;
        chk("div_busy1", fu_busy, 5'b00100);
        chk("div_cause", stall_cause, 3'b100);
        next();
        dec_valid = 1; func_unit = FU_ALU0; latency = 4; #1;
        chk("alu0_issue", issue, 1);
        chk("div_busy2", fu_busy, 5'b00100);
        next();
        dec_valid = 1; func_unit = FU_DIV; latency = 4; #1;
        chk("div_busy3", stall, 1);
        next();
        dec_valid = 1; func_unit = FU_DIV; latency = 1; #1;
        chk("div_free", issue, 1);
        chk("div_free_busy", fu_busy, 0);
        next();
        dec_valid = 1; func_unit = 3'd7; latency = 4; #1;
        chk("fu7_issue", issue, 1);
        next();
        dec_valid = 1; func_unit = FU_ALU1; latency = 4; #1;
        chk("alu1_issue", issue, 1);
        chk("alu1_busy", fu_busy, 0);

        next();
        dec_valid = 1; pred_dest_valid = 1; pred_dest_addr = 2; #1;
        chk("p2_dest", issue, 1);
        next();
        dec_valid = 1; pred_ins = 1; pred_addr = 2; #1;
        chk("p2_pvalid", predicate_valid, 0);
        chk("p2_stall", stall, 1);
        chk("p2_cause", stall_cause, 3'b001);
        next();
        dec_valid = 1; pred_ins = 1; pred_addr = 2;
        wr_pred_en = 1; wr_pred_addr = 2; #1;
        chk("p2_wb_pvalid", predicate_valid, BYP);
        next();
        dec_valid = 1; pred_ins = 1; pred_addr = 2; #1;
        chk("p2_after_pvalid", predicate_valid, 1);
        chk("p2_after_issue", issue, 1);

        next();
        dec_valid = 1; reg_dest_valid = 1; reg_dest_addr = 5;
        pred_dest_valid = 1; pred_dest_addr = 1;
        func_unit = FU_DIV; latency = 3; #1;
        chk("fl_setup", issue, 1);
        next();
        dec_valid = 1; reg_src1_valid = 1; reg_src1_addr = 3;
        flush = 1; wr_reg_en = 1; wr_reg_addr = 5; #1;
        chk("fl_issue", issue, 0);
        chk("fl_stall", stall, 1);
        chk("fl_busy", fu_busy, 5'b00100);
        next();
        dec_valid = 1; reg_src1_valid = 1; reg_src1_addr = 5;
        pred_ins = 1; pred_addr = 1; func_unit = FU_DIV; #1;
        chk("fl_clear_issue", issue, 1);
        chk("fl_clear_busy", fu_busy, 0);
        chk("fl_clear_err", sb_error, 0);
        next();
        wr_reg_en = 1; wr_reg_addr = 5;
        next(); #1;
        chk("underflow_err", sb_error, 1);

        next();
        dec_valid = 1; reg_dest_valid = 1; reg_dest_addr = 9;
        func_unit = FU_DIV; latency = 5; #1;
        chk("r9_issue", issue, 1);
        next();
        #1 reset = 1; #1;
        chk("async_err", sb_error, 0);
        chk("async_busy", fu_busy, 0);
        next();
        reset = 0;
        next();
        dec_valid = 1; reg_src1_valid = 1; reg_src1_addr = 9;
        func_unit = FU_DIV; #1;
        chk("r9_after_rst", issue, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
